// File: rtl/cpu_pkg.sv
// Shared CPU-side definitions used by the memory arbiter.
//   ADDR_W / DATA_W : unified memory address and data widths
//   arb_state_e     : arbiter FSM states
//   port_e          : requester identity, used for last_grant / ownership
//   GNT_IF / GNT_D  : bit positions in the one-hot grant vector
package cpu_pkg;
  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    IF_BUSY = 2'd1,
    D_BUSY  = 2'd2
  } arb_state_e;

  typedef enum logic {
    PORT_IF = 1'b0,
    PORT_D  = 1'b1
  } port_e;

  localparam int GNT_IF = 0;
  localparam int GNT_D  = 1;
endpackage

// File: rtl/mem_arb_rr.sv
// 2-way round-robin picker.
//   if_elig_i, d_elig_i : port may be granted this cycle
//   last_i              : port served most recently
//   gnt_o               : one-hot grant (GNT_IF / GNT_D), zero if nobody eligible
module mem_arb_rr
  import cpu_pkg::*;
(
  input  logic       if_elig_i,
  input  logic       d_elig_i,
  input  port_e      last_i,
  output logic [1:0] gnt_o
);

  always_comb begin
    gnt_o = 2'b00;
    if (if_elig_i && d_elig_i) begin
      // Tie: the port not served last wins.
      if (last_i == PORT_D) gnt_o[GNT_IF] = 1'b1;
      else                  gnt_o[GNT_D]  = 1'b1;
    end else if (if_elig_i) begin
      gnt_o[GNT_IF] = 1'b1;
    end else if (d_elig_i) begin
      gnt_o[GNT_D] = 1'b1;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates instruction-fetch and data ports onto one shared unified memory.
// Ports:
//   clk_i, rst_i               : clock, async active-high reset
//   if_req_i/if_addr_i         : fetch request (held until if_ack_o)
//   if_data_o/if_ack_o         : registered fetch data, one-cycle completion pulse
//   d_req_i/d_we_i/d_addr_i/d_wdata_i : data request (held until d_ack_o)
//   d_rdata_o/d_ack_o          : registered load data, one-cycle completion pulse
//   stall_o                    : pipeline freeze while any request is outstanding
//   err_o                      : one-cycle pulse when a transaction is aborted on timeout
//   mem_*                      : shared memory bus; request fields held until ack/abort
// TIMEOUT (1..255) is the number of wait cycles after grant before abort.
module mem_arbiter
  import cpu_pkg::*;
#(
  parameter int TIMEOUT = 255
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              if_req_i,
  input  logic [ADDR_W-1:0] if_addr_i,
  output logic [DATA_W-1:0] if_data_o,
  output logic              if_ack_o,
  input  logic              d_req_i,
  input  logic              d_we_i,
  input  logic [ADDR_W-1:0] d_addr_i,
  input  logic [DATA_W-1:0] d_wdata_i,
  output logic [DATA_W-1:0] d_rdata_o,
  output logic              d_ack_o,
  output logic              stall_o,
  output logic              err_o,
  output logic              mem_req_o,
  output logic              mem_we_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [DATA_W-1:0] mem_wdata_o,
  input  logic [DATA_W-1:0] mem_rdata_i,
  input  logic              mem_ack_i
);

  // Abort fires on the edge where the counter already holds TIMEOUT-1,
  // i.e. TIMEOUT edges after the grant edge.
  localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);

  arb_state_e        state_q, state_d;
  port_e             last_q, last_d;
  logic [7:0]        cnt_q, cnt_d;
  logic [DATA_W-1:0] if_data_q, if_data_d, d_rdata_q, d_rdata_d;
  logic              if_ack_q, if_ack_d, d_ack_q, d_ack_d, err_q, err_d;
  logic              mem_req_q, mem_req_d, mem_we_q, mem_we_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;

  logic       pick_if, pick_d, done, arb_go;
  port_e      owner, pick_last;
  logic [1:0] gnt;

  assign owner = (state_q == D_BUSY) ? PORT_D : PORT_IF;

  // A port whose ack is high this cycle still shows its old request; it is
  // not eligible. The port finishing now is masked too so that a completing
  // transaction can only hand over to the other side.
  assign pick_if   = if_req_i & ~if_ack_q & (state_q != IF_BUSY);
  assign pick_d    = d_req_i  & ~d_ack_q  & (state_q != D_BUSY);
  assign pick_last = (state_q == IDLE) ? last_q : owner;

  mem_arb_rr u_rr (
    .if_elig_i (pick_if),
    .d_elig_i  (pick_d),
    .last_i    (pick_last),
    .gnt_o     (gnt)
  );

  always_comb begin
    state_d     = state_q;
    last_d      = last_q;
    cnt_d       = cnt_q;
    if_data_d   = if_data_q;
    d_rdata_d   = d_rdata_q;
    if_ack_d    = 1'b0;
    d_ack_d     = 1'b0;
    err_d       = 1'b0;
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    done        = 1'b0;
    arb_go      = 1'b0;

    case (state_q)
      IDLE: arb_go = 1'b1;
      IF_BUSY, D_BUSY: begin
        if (mem_ack_i) begin
          done = 1'b1;
          if (owner == PORT_IF) begin
            if_data_d = mem_rdata_i;
            if_ack_d  = 1'b1;
          end else begin
            if (!mem_we_q) d_rdata_d = mem_rdata_i;
            d_ack_d = 1'b1;
          end
        end else if (cnt_q == TO_LAST) begin
          done  = 1'b1;
          err_d = 1'b1;
          if (owner == PORT_IF) if_ack_d = 1'b1;
          else                  d_ack_d  = 1'b1;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
        if (done) begin
          last_d    = owner;
          mem_req_d = 1'b0;
          state_d   = IDLE;
          arb_go    = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    // Grant (from IDLE, or straight from a completing BUSY state).
    if (arb_go) begin
      if (gnt[GNT_IF]) begin
        state_d     = IF_BUSY;
        mem_req_d   = 1'b1;
        mem_we_d    = 1'b0;
        mem_addr_d  = if_addr_i;
        mem_wdata_d = '0;
        cnt_d       = 8'd0;
      end else if (gnt[GNT_D]) begin
        state_d     = D_BUSY;
        mem_req_d   = 1'b1;
        mem_we_d    = d_we_i;
        mem_addr_d  = d_addr_i;
        mem_wdata_d = d_wdata_i;
        cnt_d       = 8'd0;
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= IDLE;
      last_q      <= PORT_IF;
      cnt_q       <= 8'd0;
      if_data_q   <= '0;
      d_rdata_q   <= '0;
      if_ack_q    <= 1'b0;
      d_ack_q     <= 1'b0;
      err_q       <= 1'b0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
    end else begin
      state_q     <= state_d;
      last_q      <= last_d;
      cnt_q       <= cnt_d;
      if_data_q   <= if_data_d;
      d_rdata_q   <= d_rdata_d;
      if_ack_q    <= if_ack_d;
      d_ack_q     <= d_ack_d;
      err_q       <= err_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
    end
  end

  assign if_data_o   = if_data_q;
  assign d_rdata_o   = d_rdata_q;
  assign if_ack_o    = if_ack_q;
  assign d_ack_o     = d_ack_q;
  assign err_o       = err_q;
  assign mem_req_o   = mem_req_q;
  assign mem_we_o    = mem_we_q;
  assign mem_addr_o  = mem_addr_q;
  assign mem_wdata_o = mem_wdata_q;
  assign stall_o     = (if_req_i & ~if_ack_q) | (d_req_i & ~d_ack_q);

endmodule
